// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// Valid/ready semantics: a transfer happens on a rising edge where both
// valid and ready are high. Data is stable whenever valid is high, and
// valid never depends combinationally on ready.
interface fetch_queue_if;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_incPC;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_incPC;
  logic [31:0] out_instr;
  logic        out_ready;

  // Pipeline side: drives fetched entries and the decode-stall signal.
  modport master (
    output in_valid, in_pc, in_incPC, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_incPC, out_instr
  );

  // Queue side.
  modport slave (
    input  in_valid, in_pc, in_incPC, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_incPC, out_instr
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode. Holds {PC, PC+4, instr}
// entries and shows the oldest one to decode (show-ahead). in_ready comes
// from registered occupancy only, so a full queue never accepts a push
// even when decode pops in the same cycle. flush empties the queue in
// one cycle and overrides any push or pop.
module fetch_queue #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h54000000
) (
  input  logic                     clk,
  input  logic                     rst,
  fetch_queue_if.slave             bus,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int             AW     = $clog2(DEPTH);
  localparam logic [AW:0]    L_FULL = (AW+1)'(DEPTH);

  logic [95:0]   r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_push;
  logic          w_pop;
  logic [95:0]   w_head_entry;

  assign w_in_ready   = (r_count != L_FULL);
  assign w_out_valid  = (r_count != '0);
  assign w_push       = bus.in_valid & w_in_ready;
  assign w_pop        = w_out_valid & bus.out_ready;
  assign w_head_entry = r_mem[r_head];

  // Pointers and occupancy; reset and flush both return to empty at entry 0.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates the outputs.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_push)
      r_mem[r_tail] <= {bus.in_pc, bus.in_incPC, bus.in_instr};
  end

  // Show-ahead head entry, with NOP and zero PCs while empty.
  always_comb begin
    bus.in_ready  = w_in_ready;
    bus.out_valid = w_out_valid;
    bus.out_pc    = '0;
    bus.out_incPC = '0;
    bus.out_instr = NOP;
    if (w_out_valid) begin
      bus.out_pc    = w_head_entry[95:64];
      bus.out_incPC = w_head_entry[63:32];
      bus.out_instr = w_head_entry[31:0];
    end
  end

  assign count = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=2).
module tb_fetch_queue;
  localparam logic [31:0] NOP = 32'h54000000;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] count;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(2), .NOP(NOP)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .flush (flush),
    .count (count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs changed after return are set 1ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_incPC = pc + 32'd4;
    bus.in_instr = instr;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hDEAD0000, 32'hFFFFFFFF);
    step();
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, NOP);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_incpc", bus.out_incPC, 32'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("post_rst_count", 32'(count), 32'd0);

    // Fill and stall
    drive(1'b1, 32'h100, 32'hA);
    step();
    chk("fill1_count", 32'(count), 32'd1);
    chk("fill1_out_pc", bus.out_pc, 32'h100);
    drive(1'b1, 32'h104, 32'hB);
    step();
    chk("fill2_count", 32'(count), 32'd2);
    chk("fill2_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fill2_out_pc", bus.out_pc, 32'h100);
    chk("fill2_out_incpc", bus.out_incPC, 32'h104);
    chk("fill2_out_instr", bus.out_instr, 32'hA);
    drive(1'b1, 32'h108, 32'hC);
    step();
    chk("full_ignore_count", 32'(count), 32'd2);
    chk("full_ignore_out_pc", bus.out_pc, 32'h100);
    drive(1'b0, 32'h0, 32'h0);

    // Drain in order
    bus.out_ready = 1'b1;
    step();
    chk("drain1_out_instr", bus.out_instr, 32'hB);
    chk("drain1_out_pc", bus.out_pc, 32'h104);
    chk("drain1_in_ready", 32'(bus.in_ready), 32'd1);
    chk("drain1_count", 32'(count), 32'd1);
    step();
    chk("drain2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("drain2_out_instr", bus.out_instr, NOP);
    chk("drain2_out_pc", bus.out_pc, 32'd0);
    chk("drain2_count", 32'(count), 32'd0);

    // Streaming across pointer wrap
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'(4 * i), 32'h1000 + 32'(i));
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      exp_q.push_back(32'(4 * i));
      step();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_out_pc", bus.out_pc, exp_q[0]);
      chk("stream_out_incpc", bus.out_incPC, exp_q[0] + 32'd4);
      chk("stream_out_instr", bus.out_instr, 32'h1000 + 32'(i));
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("stream_end_count", 32'(count), 32'd0);
    bus.out_ready = 1'b0;

    // Flush collision with push and pop
    drive(1'b1, 32'h200, 32'h20);
    step();
    chk("flush_pre_count", 32'(count), 32'd1);
    drive(1'b1, 32'h204, 32'h21);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_out_instr", bus.out_instr, NOP);
    drive(1'b1, 32'h300, 32'h30);
    step();
    chk("post_flush_out_pc", bus.out_pc, 32'h300);
    chk("post_flush_out_instr", bus.out_instr, 32'h30);
    chk("post_flush_count", 32'(count), 32'd1);

    // Reset mid-operation from full
    drive(1'b1, 32'h304, 32'h31);
    step();
    chk("mid_full_count", 32'(count), 32'd2);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h308, 32'h32);
    step();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_instr", bus.out_instr, NOP);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Captures {PC, PC+4, instruction word} produced each cycle by fetch and instruction memory.
- Presents the oldest entry to decode in show-ahead form.
- Back-pressures fetch (PC hold) when full, and supports a single-cycle flush on taken branch/jump redirect.

Parameters:
- DEPTH, 2, number of entries; power of two, at least 2.
- NOP, 32'h54000000, instruction word driven on out_instr when the queue is empty (DLX nop encoding).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents a valid entry this cycle.
- in_pc  input  32  curPC of the fetched instruction.
- in_incPC  input  32  PC + 4 of the fetched instruction.
- in_instr  input  32  instruction word from instruction memory.
- in_ready  output  1  queue accepts an entry this cycle; fetch holds PC when 0.
- out_valid  output  1  head entry valid.
- out_pc  output  32  head entry PC.
- out_incPC  output  32  head entry PC + 4.
- out_instr  output  32  head entry instruction; NOP when empty.
- out_ready  input  1  decode consumes the head this cycle (not stalled).
- flush  input  1  discard all entries (redirect).
- count  output  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage: DEPTH x 96-bit register array, head pointer, tail pointer (log2(DEPTH) bits, wrap modulo DEPTH), count register.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It is registered-state only; there is no combinational path from out_ready, so there is no push while full even if a pop occurs in the same cycle.
- out_valid = (count != 0).
- out_pc, out_incPC and out_instr are read combinationally from the head entry.
- When empty: out_instr = NOP, out_pc = 0, out_incPC = 0.
- Latency: an entry pushed at edge k is visible at the outputs in the cycle after edge k (1 cycle). There is no bypass when empty.
- Per edge, in priority order:
  - rst: head = tail = count = 0. Storage contents are don't-care. After reset: in_ready = 1, out_valid = 0, out_instr = NOP, out_pc = out_incPC = 0, count = 0.
  - flush (rst = 0): head = tail = count = 0. Any push or pop in the same cycle is ignored; the entry presented that cycle is dropped.
  - push only: write the entry at tail, tail + 1, count + 1.
  - pop only: head + 1, count - 1.
  - push and pop: write at tail, tail + 1, head + 1, count unchanged. This can only occur with 0 < count < DEPTH.
  - neither: hold.
- Pointer wrap: the pointer after DEPTH-1 is 0. Ordering is strictly FIFO across wrap.
- Pop while empty is impossible (out_valid = 0). Push while full is impossible (in_ready = 0). Inputs in those cycles are ignored with no state change.
- Reset or flush mid-stream discards all occupied entries. The first push after reset/flush lands in entry 0.
- Entry contents are stored unmodified; no arithmetic is performed on PC values.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid = 1. Required: count = 0, out_valid = 0, out_instr = 32'h54000000, in_ready = 1, and nothing is captured.
- Fill and stall: out_ready = 0; push PC 0x100/0x104 instr 0xA, then PC 0x104/0x108 instr 0xB. Required: count = 2, in_ready = 0, out_pc = 0x100. A third in_valid with PC 0x108 is ignored while full.
- Drain in order: from full, out_ready = 1 for 2 cycles. Required: out_instr reads 0xA then 0xB, then out_valid = 0 and out_instr = NOP; in_ready = 1 after the first pop.
- Streaming: in_valid = out_ready = 1 continuously with PC 0x0, 0x4, 0x8, ... Required: count stays 1 after the first cycle, out_pc lags in_pc by 1 cycle, and 8 pushes cross pointer wrap with no reorder or loss.
- Flush collision: count = 1 (PC 0x200), then assert flush together with a push of PC 0x204 and out_ready = 1. Required: count = 0, out_valid = 0 next cycle. The next push of PC 0x300 appears as out_pc = 0x300 with count = 1.
- Reset mid-operation: full queue, then assert rst together with push and pop. Required: count = 0, out_valid = 0, in_ready = 1 next cycle.
